pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 112 +++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch front end: issues ROM reads, holds each fetched word for the
// consumer and follows jump redirects, including jumps that land mid-request.
module pc_fetch #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        jump,
    input  logic [15:0] target,
    input  logic        stall,
    output logic        rom_req,
    output logic [15:0] rom_addr,
    input  logic        rom_ack,
    input  logic [15:0] rom_data,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fetch_addr_q, fetch_addr_d;
    logic [15:0] redir_addr_q, redir_addr_d;
    logic        redir_pend_q, redir_pend_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_q, pc_d;

    // Handshakes: the ROM side completes on rom_req & rom_ack, with rom_req and
    // rom_addr held until then. The consumer side transfers on instr_valid &
    // instr_ready & !jump; instr/pc stay put until transferred or dropped by a jump.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        redir_addr_d = redir_addr_q;
        redir_pend_d = redir_pend_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        unique case (state_q)
            IDLE: begin
                if (jump) begin
                    fetch_addr_d = target;
                end else if (!stall) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!rom_ack) begin
                    // A read in flight cannot be cancelled; remember the newest redirect.
                    if (jump) begin
                        redir_addr_d = target;
                        redir_pend_d = 1'b1;
                    end
                end else if (jump) begin
                    fetch_addr_d = target;
                    redir_pend_d = 1'b0;
                    state_d      = IDLE;
                end else if (redir_pend_q) begin
                    fetch_addr_d = redir_addr_q;
                    redir_pend_d = 1'b0;
                    state_d      = IDLE;
                end else begin
                    instr_d      = rom_data;
                    pc_d         = fetch_addr_q;
                    fetch_addr_d = fetch_addr_q + 16'd1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (jump) begin
                    fetch_addr_d = target;
                    state_d      = IDLE;
                end else if (instr_ready) begin
                    state_d = stall ? IDLE : REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= RESET_ADDR;
            redir_addr_q <= 16'h0000;
            redir_pend_q <= 1'b0;
            instr_q      <= 16'h0000;
            pc_q         <= RESET_ADDR;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            redir_addr_q <= redir_addr_d;
            redir_pend_q <= redir_pend_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
        end
    end

    assign rom_req     = (state_q == REQ);
    assign instr_valid = (state_q == HOLD);
    assign rom_addr    = fetch_addr_q;
    assign instr       = instr_q;
    assign pc          = pc_q;

endmodule
